// File: rtl/qbert_sysid_check_pkg.sv
// rtl/qbert_sysid_check_pkg.sv - shared types and constants for the sysid boot check
package qbert_sysid_check_pkg;

    localparam int CNT_W = 16;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd34;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1459253078;

    typedef enum logic [2:0] {
        ST_RD_ID,
        ST_RD_TS,
        ST_COMPARE,
        ST_GAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/qbert_sysid_check_timer.sv
// rtl/qbert_sysid_check_timer.sv - loadable down-counter with zero flag
module qbert_sysid_check_timer
    import qbert_sysid_check_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load wins over decrement; the count saturates at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/qbert_sysid_check_ctrl.sv
// rtl/qbert_sysid_check_ctrl.sv - boot-time sysid check sequencer gating CPU reset
module qbert_sysid_check_ctrl
    import qbert_sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int          MAX_RETRIES    = 3,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          RETRY_GAP      = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [2:0]  retry_count,
    output logic        cpu_reset_n
);

    // Timers are preloaded with N-1 so the N-th cycle sees the zero flag.
    localparam logic [CNT_W-1:0] STALL_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(RETRY_GAP - 1);
    localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRIES);

    state_t state;

    logic stall;
    logic stall_zero;
    logic gap_zero;
    logic timeout;
    logic words_match;
    logic attempt_bad;
    logic can_retry;

    assign stall       = avm_read && avm_waitrequest;
    assign timeout     = stall && stall_zero;
    assign words_match = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
    assign attempt_bad = timeout || ((state == ST_COMPARE) && !words_match);
    assign can_retry   = (retry_count < RETRY_LIMIT);

    // Reloads whenever the bus is idle or a read is accepted, so each read
    // starts with a fresh stall budget.
    qbert_sysid_check_timer u_stall_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (!stall),
        .load_value (STALL_LOAD),
        .dec        (stall),
        .zero       (stall_zero)
    );

    qbert_sysid_check_timer u_gap_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (state != ST_GAP),
        .load_value (GAP_LOAD),
        .dec        (state == ST_GAP),
        .zero       (gap_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_RD_ID;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            retry_count <= '0;
            cpu_reset_n <= 1'b0;
        end else if (attempt_bad) begin
            avm_read <= 1'b0;
            if (can_retry) begin
                retry_count <= retry_count + 3'd1;
                state       <= ST_GAP;
            end else begin
                state       <= ST_DONE;
                busy        <= 1'b0;
                done        <= 1'b1;
                fail        <= 1'b1;
                cpu_reset_n <= 1'b0;
            end
        end else begin
            case (state)
                ST_RD_ID: begin
                    if (!avm_read) begin
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                    end else if (!avm_waitrequest) begin
                        id_value    <= avm_readdata;
                        avm_address <= 1'b1;
                        state       <= ST_RD_TS;
                    end
                end
                ST_RD_TS: begin
                    if (!avm_waitrequest) begin
                        ts_value <= avm_readdata;
                        avm_read <= 1'b0;
                        state    <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    state       <= ST_DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    pass        <= 1'b1;
                    cpu_reset_n <= 1'b1;
                end
                ST_GAP: begin
                    if (gap_zero) begin
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        state       <= ST_RD_ID;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                        retry_count <= '0;
                        state       <= ST_RD_ID;
                    end
                end
                default: state <= ST_RD_ID;
            endcase
        end
    end

endmodule

// File: tb/tb_qbert_sysid_check_ctrl.sv
// tb/tb_qbert_sysid_check_ctrl.sv - directed self-checking bench for qbert_sysid_check_ctrl
module tb_qbert_sysid_check_ctrl;

    localparam logic [31:0] GOOD_ID = 32'd34;
    localparam logic [31:0] GOOD_TS = 32'd1459253078;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
    logic [2:0]  retry_count;
    logic        cpu_reset_n;

    logic [31:0] id_data  = GOOD_ID;
    logic [31:0] ts_data  = GOOD_TS;
    logic        ts_stall = 1'b0;

    logic        reset2_n = 1'b0;
    logic        start2 = 1'b0;
    logic        address2;
    logic        read2;
    logic        waitrequest2 = 1'b1;
    logic [31:0] readdata2 = 32'hDEAD_BEEF;
    logic [31:0] id_value2;
    logic [31:0] ts_value2;
    logic        busy2;
    logic        done2;
    logic        pass2;
    logic        fail2;
    logic [2:0]  retry_count2;
    logic        cpu_reset2_n;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign avm_readdata    = avm_address ? ts_data : id_data;
    assign avm_waitrequest = ts_stall && avm_address;

    qbert_sysid_check_ctrl dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .id_value        (id_value),
        .ts_value        (ts_value),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail            (fail),
        .retry_count     (retry_count),
        .cpu_reset_n     (cpu_reset_n)
    );

    qbert_sysid_check_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
        .clock           (clock),
        .reset_n         (reset2_n),
        .start           (start2),
        .avm_address     (address2),
        .avm_read        (read2),
        .avm_waitrequest (waitrequest2),
        .avm_readdata    (readdata2),
        .id_value        (id_value2),
        .ts_value        (ts_value2),
        .busy            (busy2),
        .done            (done2),
        .pass            (pass2),
        .fail            (fail2),
        .retry_count     (retry_count2),
        .cpu_reset_n     (cpu_reset2_n)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Start is sampled in the DONE cycle; returns at the first cycle of the re-run.
    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        step(2);
        check("rst_read", avm_read, 0);
        check("rst_addr", avm_address, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_cpu", cpu_reset_n, 0);
        check("rst_id", id_value, 0);

        // zero-wait pass
        reset_n = 1'b1;
        check("p_c0_read", avm_read, 0);
        step(1);
        check("p_c1_read", avm_read, 1);
        check("p_c1_addr", avm_address, 0);
        step(1);
        check("p_c2_addr", avm_address, 1);
        check("p_c2_id", id_value, GOOD_ID);
        step(1);
        check("p_c3_read", avm_read, 0);
        check("p_c3_ts", ts_value, GOOD_TS);
        check("p_c3_done", done, 0);
        step(1);
        check("p_c4_done", done, 1);
        check("p_c4_pass", pass, 1);
        check("p_c4_cpu", cpu_reset_n, 1);
        check("p_c4_busy", busy, 0);
        check("p_c4_retry", retry_count, 0);

        // re-run with bad timestamp; start while busy is ignored
        ts_data = GOOD_TS + 32'd1;
        pulse_start();
        check("r_c0_busy", busy, 1);
        check("r_c0_pass", pass, 0);
        check("r_c0_cpu", cpu_reset_n, 1);
        step(4);
        check("r_c4_retry", retry_count, 1);
        check("r_c4_read", avm_read, 0);
        pulse_start();
        check("r_ign_retry", retry_count, 1);
        check("r_ign_busy", busy, 1);
        check("r_ign_read", avm_read, 0);
        step(55);
        check("r_c60_done", done, 0);
        check("r_c60_cpu", cpu_reset_n, 1);
        step(1);
        check("r_c61_fail", fail, 1);
        check("r_c61_pass", pass, 0);
        check("r_c61_retry", retry_count, 3);
        check("r_c61_cpu", cpu_reset_n, 0);

        // ID wrong on every attempt
        ts_data = GOOD_TS;
        id_data = 32'd35;
        pulse_start();
        check("f_c0_fail", fail, 0);
        check("f_c0_retry", retry_count, 0);
        step(19);
        check("f_c19_read", avm_read, 0);
        step(1);
        check("f_c20_read", avm_read, 1);
        check("f_c20_addr", avm_address, 0);
        step(40);
        check("f_c60_done", done, 0);
        step(1);
        check("f_c61_fail", fail, 1);
        check("f_c61_retry", retry_count, 3);
        check("f_c61_cpu", cpu_reset_n, 0);
        check("f_c61_id", id_value, 35);

        // ID wrong on the first attempt only
        pulse_start();
        step(4);
        id_data = GOOD_ID;
        step(15);
        check("o_c19_read", avm_read, 0);
        check("o_c19_retry", retry_count, 1);
        step(1);
        check("o_c20_read", avm_read, 1);
        check("o_c20_addr", avm_address, 0);
        step(3);
        check("o_c23_pass", pass, 1);
        check("o_c23_done", done, 1);
        check("o_c23_retry", retry_count, 1);
        check("o_c23_cpu", cpu_reset_n, 1);

        // reset while the timestamp read is stalled
        ts_stall = 1'b1;
        pulse_start();
        step(3);
        check("x_stall_read", avm_read, 1);
        check("x_stall_addr", avm_address, 1);
        reset_n = 1'b0;
        #1;
        check("x_async_read", avm_read, 0);
        check("x_async_cpu", cpu_reset_n, 0);
        check("x_async_busy", busy, 1);
        step(2);
        ts_stall = 1'b0;
        reset_n = 1'b1;
        step(4);
        check("x_c4_pass", pass, 1);
        check("x_c4_cpu", cpu_reset_n, 1);

        // permanent waitrequest with a 4-cycle timeout
        reset2_n = 1'b1;
        step(4);
        check("t_c4_read", read2, 1);
        check("t_c4_addr", address2, 0);
        step(1);
        check("t_c5_read", read2, 0);
        check("t_c5_retry", retry_count2, 1);
        check("t_c5_busy", busy2, 1);
        step(16);
        check("t_c21_read", read2, 1);
        check("t_c21_addr", address2, 0);
        step(43);
        check("t_c64_done", done2, 0);
        check("t_c64_addr", address2, 0);
        step(1);
        check("t_c65_fail", fail2, 1);
        check("t_c65_retry", retry_count2, 3);
        check("t_c65_cpu", cpu_reset2_n, 0);
        check("t_c65_read", read2, 0);
        check("t_c65_id", id_value2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
